// File: rtl/fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_issue_ctrl
//
// Purpose:
//   Initiator-side controller for the FPU request/response handshake. It takes
//   host commands, tags each with a reorder slot index, and issues them to the
//   FPU through a one-entry issue register. Results may come back out of order.
//   They are parked in a tag-indexed reorder buffer and retired to the host in
//   program order. The status bits of retired results are ORed into sticky
//   fflags.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cmd_*                   host command channel (valid/ready + payload)
//   fpu_*_o, fpu_in_*       FPU request channel (registered payload + tag)
//   fpu_flush_o             FPU flush, follows flush_i combinationally
//   fpu_result_i .. fpu_out_ready_o   FPU response channel (tagged)
//   rsp_*                   in-order response channel to the host
//   fflags_o, fflags_clr_i  sticky exception flags and their clear
//   flush_i                 abort every outstanding op
//   outstanding_o, idle_o   occupancy / idle indication (idle also needs !fpu_busy_i)
//   proto_err_o             sticky: result arrived for a free or already-filled slot
//
// Optional feature (macro FPU_ISSUE_TIMEOUT_EN):
//   Adds the sticky output timeout_o. A watchdog counts the cycles during
//   which the oldest slot is reserved but still has no result. It sets
//   timeout_o when the count reaches TimeoutCycles.
// -----------------------------------------------------------------------------
module fpu_issue_ctrl #(
  parameter int Width         = 16,
  parameter int Depth         = 4,
  parameter int TagWidth      = $clog2(Depth),
  parameter int TimeoutCycles = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // host command channel
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [3*Width-1:0]         cmd_operands_i,
  input  logic [3:0]                 cmd_op_i,
  input  logic                       cmd_op_mod_i,
  input  logic [2:0]                 cmd_rnd_mode_i,
  input  logic [2:0]                 cmd_src_fmt_i,
  input  logic [2:0]                 cmd_dst_fmt_i,
  // FPU request channel
  output logic [3*Width-1:0]         fpu_operands_o,
  output logic [3:0]                 fpu_op_o,
  output logic                       fpu_op_mod_o,
  output logic [2:0]                 fpu_rnd_mode_o,
  output logic [2:0]                 fpu_src_fmt_o,
  output logic [2:0]                 fpu_dst_fmt_o,
  output logic [TagWidth-1:0]        fpu_tag_o,
  output logic                       fpu_in_valid_o,
  input  logic                       fpu_in_ready_i,
  output logic                       fpu_flush_o,
  // FPU response channel
  input  logic [Width-1:0]           fpu_result_i,
  input  logic [4:0]                 fpu_status_i,
  input  logic [TagWidth-1:0]        fpu_tag_i,
  input  logic                       fpu_out_valid_i,
  output logic                       fpu_out_ready_o,
  // host response channel
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [Width-1:0]           rsp_result_o,
  output logic [4:0]                 rsp_status_o,
  // flags / control / status
  output logic [4:0]                 fflags_o,
  input  logic                       fflags_clr_i,
  input  logic                       flush_i,
  output logic [$clog2(Depth):0]     outstanding_o,
  output logic                       idle_o,
  input  logic                       fpu_busy_i,
`ifdef FPU_ISSUE_TIMEOUT_EN
  output logic                       timeout_o,
`endif
  output logic                       proto_err_o
);

  localparam int CntWidth = $clog2(Depth) + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [TagWidth-1:0] wr_ptr_reg;
  logic [TagWidth-1:0] rd_ptr_reg;
  logic [CntWidth-1:0] count_reg;

  // Issue register
  logic                iss_valid_reg;
  logic [3*Width-1:0]  iss_operands_reg;
  logic [3:0]          iss_op_reg;
  logic                iss_op_mod_reg;
  logic [2:0]          iss_rnd_mode_reg;
  logic [2:0]          iss_src_fmt_reg;
  logic [2:0]          iss_dst_fmt_reg;
  logic [TagWidth-1:0] iss_tag_reg;

  // Reorder buffer: per-slot reserved/valid bits plus result storage
  logic [Depth-1:0]    rsv_reg;
  logic [Depth-1:0]    rsv_next;
  logic [Depth-1:0]    vld_reg;
  logic [Depth-1:0]    vld_next;
  logic [Width-1:0]    res_mem [Depth];
  logic [4:0]          sts_mem [Depth];

  logic [4:0]          fflags_reg;
  logic                proto_err_reg;

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  logic issue_hs;
  logic accept;
  logic cmpl;
  logic cmpl_ok;
  logic retire;

  assign issue_hs = iss_valid_reg && fpu_in_ready_i;

  // A free issue register, or one that drains this very cycle, can take a new
  // command. Slot space was reserved at accept, so count<Depth is the only
  // capacity limit.
  assign cmd_ready_o = !rst_i && !flush_i && (count_reg < CntWidth'(Depth)) &&
                       (!iss_valid_reg || issue_hs);
  assign accept      = cmd_valid_i && cmd_ready_o;

  assign fpu_out_ready_o = !rst_i && !flush_i;
  assign cmpl            = fpu_out_valid_i && fpu_out_ready_o;
  assign cmpl_ok         = cmpl && rsv_reg[fpu_tag_i] && !vld_reg[fpu_tag_i];

  assign rsp_valid_o  = vld_reg[rd_ptr_reg];
  assign rsp_result_o = res_mem[rd_ptr_reg];
  assign rsp_status_o = sts_mem[rd_ptr_reg];
  // The response handshake is suppressed while a flush is in progress.
  assign retire       = rsp_valid_o && rsp_ready_i && !flush_i && !rst_i;

  // ---------------------------------------------------------------------------
  // Issue register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      iss_valid_reg <= 1'b0;
    end else if (accept) begin
      iss_valid_reg <= 1'b1;
    end else if (issue_hs) begin
      iss_valid_reg <= 1'b0;
    end
  end

  // The payload has no reset. It is only observed while iss_valid_reg is set,
  // and it is held until the handshake because accept needs a draining register.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      iss_operands_reg <= cmd_operands_i;
      iss_op_reg       <= cmd_op_i;
      iss_op_mod_reg   <= cmd_op_mod_i;
      iss_rnd_mode_reg <= cmd_rnd_mode_i;
      iss_src_fmt_reg  <= cmd_src_fmt_i;
      iss_dst_fmt_reg  <= cmd_dst_fmt_i;
      iss_tag_reg      <= wr_ptr_reg;
    end
  end

  assign fpu_in_valid_o = iss_valid_reg;
  assign fpu_operands_o = iss_operands_reg;
  assign fpu_op_o       = iss_op_reg;
  assign fpu_op_mod_o   = iss_op_mod_reg;
  assign fpu_rnd_mode_o = iss_rnd_mode_reg;
  assign fpu_src_fmt_o  = iss_src_fmt_reg;
  assign fpu_dst_fmt_o  = iss_dst_fmt_reg;
  assign fpu_tag_o      = iss_tag_reg;
  assign fpu_flush_o    = flush_i;

  // ---------------------------------------------------------------------------
  // Reorder slot bookkeeping
  // An accept and a retire can never target the same slot in one cycle. An
  // accept at wr_ptr==rd_ptr implies count==0, so that slot holds no result.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < Depth; gi++) begin : g_slot
      logic acc_here;
      logic ret_here;
      logic cmp_here;

      assign acc_here = accept  && (wr_ptr_reg == TagWidth'(gi));
      assign ret_here = retire  && (rd_ptr_reg == TagWidth'(gi));
      assign cmp_here = cmpl_ok && (fpu_tag_i  == TagWidth'(gi));

      assign rsv_next[gi] = acc_here ? 1'b1 : (ret_here ? 1'b0 : rsv_reg[gi]);
      assign vld_next[gi] = cmp_here ? 1'b1 : (ret_here ? 1'b0 : vld_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rsv_reg <= '0;
      vld_reg <= '0;
    end else begin
      rsv_reg <= rsv_next;
      vld_reg <= vld_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cmpl_ok) begin
      res_mem[fpu_tag_i] <= fpu_result_i;
      sts_mem[fpu_tag_i] <= fpu_status_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // Depth is a power of two, so the pointers wrap naturally.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + TagWidth'(accept);
      rd_ptr_reg <= rd_ptr_reg + TagWidth'(retire);
      count_reg  <= count_reg + CntWidth'(accept) - CntWidth'(retire);
    end
  end

  assign outstanding_o = count_reg;
  assign idle_o        = (count_reg == '0) && !fpu_busy_i;

  // ---------------------------------------------------------------------------
  // Sticky flags. A flush keeps both fflags and proto_err. When a retire and a
  // clear happen in the same cycle, the status of the retiring result survives.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fflags_reg <= '0;
    end else if (!flush_i) begin
      fflags_reg <= (fflags_clr_i ? 5'b0 : fflags_reg) |
                    (retire ? rsp_status_o : 5'b0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      proto_err_reg <= 1'b0;
    end else if (cmpl && !cmpl_ok) begin
      proto_err_reg <= 1'b1;
    end
  end

  assign fflags_o    = fflags_reg;
  assign proto_err_o = proto_err_reg;

`ifdef FPU_ISSUE_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Watchdog on the oldest outstanding op. The counter saturates at the limit
  // so that it cannot wrap back below it.
  // ---------------------------------------------------------------------------
  localparam int ToWidth = $clog2(TimeoutCycles + 1);
  localparam logic [ToWidth-1:0] ToLimit = ToWidth'(TimeoutCycles);

  logic [ToWidth-1:0] to_cnt_reg;
  logic               timeout_reg;
  logic               head_waiting;

  assign head_waiting = rsv_reg[rd_ptr_reg] && !vld_reg[rd_ptr_reg];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      to_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (retire) begin
        to_cnt_reg <= '0;
      end else if (head_waiting && (to_cnt_reg != ToLimit)) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
      if (to_cnt_reg == ToLimit) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_reg;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fpu_issue_ctrl
//
// Directed bench for fpu_issue_ctrl. A reference model tracks outstanding ops
// as an age-ordered queue. The compare process checks the DUT against this
// model on every falling edge, and literal checks pin key values from the
// scenarios by hand.
// -----------------------------------------------------------------------------
module tb_fpu_issue_ctrl;

  localparam int W = 16;
  localparam int D = 4;
  localparam int TW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3*W-1:0]    cmd_operands;
  logic [3:0]        cmd_op;
  logic              cmd_op_mod;
  logic [2:0]        cmd_rnd_mode;
  logic [2:0]        cmd_src_fmt;
  logic [2:0]        cmd_dst_fmt;
  logic [3*W-1:0]    fpu_operands;
  logic [3:0]        fpu_op;
  logic              fpu_op_mod;
  logic [2:0]        fpu_rnd_mode;
  logic [2:0]        fpu_src_fmt;
  logic [2:0]        fpu_dst_fmt;
  logic [TW-1:0]     fpu_tag;
  logic              fpu_in_valid;
  logic              fpu_in_ready;
  logic              fpu_flush;
  logic [W-1:0]      fpu_result;
  logic [4:0]        fpu_status;
  logic [TW-1:0]     fpu_rtag;
  logic              fpu_out_valid;
  logic              fpu_out_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_result;
  logic [4:0]        rsp_status;
  logic [4:0]        fflags;
  logic              fflags_clr;
  logic              flush;
  logic [2:0]        outstanding;
  logic              idle;
  logic              fpu_busy;
  logic              proto_err;
`ifdef FPU_ISSUE_TIMEOUT_EN
  logic              timeout;
`endif

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.Width(W), .Depth(D), .TagWidth(TW), .TimeoutCycles(256)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_operands_i(cmd_operands), .cmd_op_i(cmd_op), .cmd_op_mod_i(cmd_op_mod),
    .cmd_rnd_mode_i(cmd_rnd_mode), .cmd_src_fmt_i(cmd_src_fmt), .cmd_dst_fmt_i(cmd_dst_fmt),
    .fpu_operands_o(fpu_operands), .fpu_op_o(fpu_op), .fpu_op_mod_o(fpu_op_mod),
    .fpu_rnd_mode_o(fpu_rnd_mode), .fpu_src_fmt_o(fpu_src_fmt), .fpu_dst_fmt_o(fpu_dst_fmt),
    .fpu_tag_o(fpu_tag), .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
    .fpu_flush_o(fpu_flush),
    .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_rtag),
    .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_status_o(rsp_status),
    .fflags_o(fflags), .fflags_clr_i(fflags_clr), .flush_i(flush),
    .outstanding_o(outstanding), .idle_o(idle), .fpu_busy_i(fpu_busy),
`ifdef FPU_ISSUE_TIMEOUT_EN
    .timeout_o(timeout),
`endif
    .proto_err_o(proto_err)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: ops in program order, oldest first. The tag of entry i is
  // (head_tag + i) mod D.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         done;
    logic [W-1:0] res;
    logic [4:0] st;
  } ent_t;

  ent_t           q[$];
  int             head_tag = 0;
  bit             m_iss_full = 0;
  logic [TW-1:0]  m_iss_tag = '0;
  logic [3*W-1:0] m_iss_ops = '0;
  logic [4:0]     m_fflags = '0;
  bit             m_perr = 0;
  bit             m_en = 0;

  // model-update scratch (used only by the update process)
  bit     u_acc, u_hs, u_ret;
  int     u_idx;
  logic [4:0] u_rst;
  ent_t   u_e;

  function automatic bit m_ready();
    return !rst && !flush && (q.size() < D) && (!m_iss_full || fpu_in_ready);
  endfunction

  function automatic bit m_rsp_valid();
    return (q.size() > 0) && q[0].done;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete(); head_tag = 0; m_iss_full = 0; m_fflags = '0; m_perr = 0; m_en = 1;
    end else if (flush) begin
      q.delete(); head_tag = 0; m_iss_full = 0;
    end else begin
      u_acc = cmd_valid && m_ready();
      u_hs  = m_iss_full && fpu_in_ready;
      u_ret = m_rsp_valid() && rsp_ready;
      u_rst = (q.size() > 0) ? q[0].st : 5'b0;
      if (fpu_out_valid) begin
        u_idx = (int'(fpu_rtag) - head_tag + D) % D;
        if (u_idx < q.size() && !q[u_idx].done) begin
          u_e = q[u_idx]; u_e.done = 1; u_e.res = fpu_result; u_e.st = fpu_status;
          q[u_idx] = u_e;
        end else begin
          m_perr = 1;
        end
      end
      m_fflags = (fflags_clr ? 5'b0 : m_fflags) | (u_ret ? u_rst : 5'b0);
      if (u_ret) begin
        void'(q.pop_front());
        head_tag = (head_tag + 1) % D;
      end
      if (u_acc) begin
        m_iss_tag = TW'((head_tag + q.size()) % D);
        m_iss_ops = cmd_operands;
        u_e.done = 0; u_e.res = '0; u_e.st = '0;
        q.push_back(u_e);
        m_iss_full = 1;
      end else if (u_hs) begin
        m_iss_full = 0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_en && !rst) begin
      chk("cmd_ready", cmd_ready, m_ready());
      chk("fpu_in_valid", fpu_in_valid, m_iss_full);
      if (m_iss_full) begin
        chk("fpu_tag", fpu_tag, m_iss_tag);
        chk("fpu_operands", fpu_operands, m_iss_ops);
      end
      chk("rsp_valid", rsp_valid, m_rsp_valid());
      if (m_rsp_valid()) begin
        chk("rsp_result", rsp_result, q[0].res);
        chk("rsp_status", rsp_status, q[0].st);
      end
      chk("outstanding", outstanding, q.size());
      chk("idle", idle, (q.size() == 0) && !fpu_busy);
      chk("fflags", fflags, m_fflags);
      chk("proto_err", proto_err, m_perr);
      chk("fpu_flush", fpu_flush, flush);
      chk("fpu_out_ready", fpu_out_ready, !flush);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; cmd_valid = 0; cmd_operands = '0; cmd_op = '0; cmd_op_mod = 0;
    cmd_rnd_mode = '0; cmd_src_fmt = 3'd2; cmd_dst_fmt = 3'd2;
    fpu_in_ready = 1; fpu_result = '0; fpu_status = '0; fpu_rtag = '0;
    fpu_out_valid = 0; rsp_ready = 0; fflags_clr = 0; flush = 0; fpu_busy = 0;
    step(); step();
    rst = 0;
  endtask

  task automatic send_result(input logic [TW-1:0] t, input logic [W-1:0] r, input logic [4:0] s);
    fpu_out_valid = 1; fpu_rtag = t; fpu_result = r; fpu_status = s;
    step();
    fpu_out_valid = 0;
  endtask

  initial begin
    do_reset();
    settle();
    chk("reset_outstanding", outstanding, 3'd0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_in_valid", fpu_in_valid, 1'b0);
    chk("reset_fflags", fflags, 5'd0);

    // Single op
    cmd_valid = 1; cmd_operands = {16'h0000, 16'h4000, 16'h3C00}; cmd_op = 4'd2;
    step();
    cmd_valid = 0;
    chk("single_in_valid", fpu_in_valid, 1'b1);
    chk("single_tag", fpu_tag, 2'd0);
    step(); step(); step();
    fpu_out_valid = 1; fpu_rtag = 0; fpu_result = 16'h4200; fpu_status = 5'd0;
    settle();
    chk("single_no_early_rsp", rsp_valid, 1'b0);
    step();
    fpu_out_valid = 0;
    chk("single_rsp_valid", rsp_valid, 1'b1);
    chk("single_rsp_result", rsp_result, 16'h4200);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("single_outstanding", outstanding, 3'd0);

    // Out of order
    do_reset();
    cmd_valid = 1; cmd_operands = 48'h1;
    step();
    cmd_operands = 48'h2;
    step();
    cmd_valid = 0;
    chk("ooo_tag1", fpu_tag, 2'd1);
    step();
    send_result(2'd1, 16'h4400, 5'd0);
    chk("ooo_wait_head", rsp_valid, 1'b0);
    send_result(2'd0, 16'h4200, 5'd0);
    chk("ooo_first", rsp_result, 16'h4200);
    rsp_ready = 1;
    step();
    chk("ooo_second", rsp_result, 16'h4400);
    chk("ooo_second_valid", rsp_valid, 1'b1);
    step();
    rsp_ready = 0;
    chk("ooo_outstanding", outstanding, 3'd0);

    // Full
    do_reset();
    cmd_valid = 1;
    for (int i = 0; i < 5; i++) begin
      cmd_operands = 48'(i + 16);
      step();
    end
    cmd_valid = 0;
    settle();
    chk("full_outstanding", outstanding, 3'd4);
    chk("full_cmd_ready", cmd_ready, 1'b0);
    send_result(2'd0, 16'h1111, 5'd0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    settle();
    chk("full_ready_after_retire", cmd_ready, 1'b1);
    cmd_valid = 1; cmd_operands = 48'hABC;
    step();
    cmd_valid = 0;
    chk("full_wrap_tag", fpu_tag, 2'd0);
    step();

    // Flush
    do_reset();
    cmd_valid = 1; cmd_operands = 48'h5;
    step();
    cmd_valid = 0;
    step();
    send_result(2'd0, 16'h2222, 5'b00100);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    cmd_valid = 1;
    for (int i = 0; i < 3; i++) begin
      cmd_operands = 48'(i + 32);
      step();
    end
    cmd_valid = 0;
    step();
    chk("flush_pre_outstanding", outstanding, 3'd3);
    flush = 1;
    settle();
    chk("flush_comb", fpu_flush, 1'b1);
    step();
    flush = 0;
    chk("flush_outstanding", outstanding, 3'd0);
    chk("flush_rsp_valid", rsp_valid, 1'b0);
    chk("flush_fflags_kept", fflags, 5'b00100);
    send_result(2'd2, 16'h3333, 5'd0);
    chk("flush_late_proto_err", proto_err, 1'b1);

    // Fflags
    do_reset();
    cmd_valid = 1; cmd_operands = 48'h7;
    step();
    cmd_operands = 48'h8;
    step();
    cmd_valid = 0;
    step();
    send_result(2'd0, 16'h0001, 5'b00001);
    send_result(2'd1, 16'h0002, 5'b10000);
    rsp_ready = 1;
    step();
    chk("fflags_first", fflags, 5'b00001);
    fflags_clr = 1;
    step();
    fflags_clr = 0; rsp_ready = 0;
    chk("fflags_clr_retire", fflags, 5'b10000);

    // Backpressure
    do_reset();
    fpu_in_ready = 0;
    cmd_valid = 1; cmd_operands = 48'hAAAA_BBBB_CCCC; cmd_op = 4'd3;
    step();
    cmd_operands = 48'h1111_2222_3333;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_valid", fpu_in_valid, 1'b1);
      chk("bp_tag", fpu_tag, 2'd0);
      chk("bp_payload", fpu_operands, 48'hAAAA_BBBB_CCCC);
      chk("bp_outstanding", outstanding, 3'd1);
      step();
    end
    fpu_in_ready = 1;
    settle();
    chk("bp_ready_at_hs", cmd_ready, 1'b1);
    step();
    cmd_valid = 0;
    chk("bp_second_tag", fpu_tag, 2'd1);
    chk("bp_second_payload", fpu_operands, 48'h1111_2222_3333);
    step();
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Initiator-side controller that drives the FPU top-level request/response handshake on behalf of a host.
- Accepts host commands, assigns each one a tag and issues it to the FPU.
- Collects FPU results, which may return out of order across opgroups, in a tag-indexed reorder buffer.
- Returns results to the host in program order and accumulates sticky fflags.

Parameters:
- Width, 16, FP datapath width; matches the FPU width.
- Depth, 4, max outstanding ops (issue register + in-flight + completed-not-retired); power of 2, ≥2.
- TagWidth, $clog2(Depth), width of the FPU tag; the tag equals the reorder slot index.
- TimeoutCycles, 256, watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  host command valid
- cmd_ready_o  out  1  host command accepted
- cmd_operands_i  in  3*Width  operands [2:0]
- cmd_op_i  in  4  operation code
- cmd_op_mod_i  in  1  operation modifier
- cmd_rnd_mode_i  in  3  rounding mode
- cmd_src_fmt_i  in  3  source format
- cmd_dst_fmt_i  in  3  destination format
- fpu_operands_o, fpu_op_o, fpu_op_mod_o, fpu_rnd_mode_o, fpu_src_fmt_o, fpu_dst_fmt_o  out  as cmd_*  registered copy of the command
- fpu_tag_o  out  TagWidth  reorder slot of the issued op
- fpu_in_valid_o  out  1  request valid
- fpu_in_ready_i  in  1  request accepted
- fpu_flush_o  out  1  FPU flush
- fpu_result_i  in  Width  result
- fpu_status_i  in  5  status {NV,DZ,OF,UF,NX}
- fpu_tag_i  in  TagWidth  result tag
- fpu_out_valid_i  in  1  result valid
- fpu_out_ready_o  out  1  result ready
- rsp_valid_o  out  1  in-order result valid
- rsp_ready_i  in  1  host accepts result
- rsp_result_o  out  Width  result
- rsp_status_o  out  5  status of this result
- fflags_o  out  5  sticky OR of retired status
- fflags_clr_i  in  1  clear fflags
- flush_i  in  1  abort all outstanding ops
- outstanding_o  out  $clog2(Depth)+1  occupied slot count
- idle_o  out  1  count==0 && !fpu_busy_i
- fpu_busy_i  in  1  FPU busy
- proto_err_o  out  1  sticky: result arrived for an unreserved or already-filled slot

Behaviour:
- Reset (rst_i high at clock edge):
  - wr_ptr=rd_ptr=0, count=0, all slot valid/reserved bits 0, issue register empty.
  - fflags_o=0, proto_err_o=0, fpu_in_valid_o=0, rsp_valid_o=0, outstanding_o=0.
  - cmd_ready_o=0 while rst_i is high.
  - Reset mid-operation discards everything; the FPU is not flushed by reset.
- Accept:
  - cmd_ready_o = !rst_i && !flush_i && count<Depth && (issue reg empty || (fpu_in_valid_o && fpu_in_ready_i)).
  - On cmd_valid_i && cmd_ready_o: load the issue register with tag=wr_ptr, mark slot wr_ptr reserved, increment wr_ptr (wraps modulo Depth), increment count.
- Issue:
  - fpu_in_valid_o = issue register full; rises the cycle after accept.
  - Payload and valid are held stable until fpu_in_ready_i; valid never depends on ready.
  - A back-to-back accept is allowed in the same cycle as the FPU handshake.
- Completion:
  - fpu_out_ready_o = !rst_i && !flush_i, always ready otherwise; space is guaranteed by the slot reservation made at accept.
  - On fpu_out_valid_i && fpu_out_ready_o: if slot[fpu_tag_i] is reserved and not yet valid, store result and status and set valid; otherwise drop the result and set proto_err_o.
- Retire:
  - rsp_valid_o = slot[rd_ptr].valid; a result written at edge t is visible after t (one cycle of latency).
  - rsp_result_o/rsp_status_o come from slot[rd_ptr].
  - On rsp_valid_o && rsp_ready_i: clear the slot, increment rd_ptr (wraps), decrement count.
- Count:
  - Simultaneous accept and retire leaves count unchanged.
  - count never exceeds Depth and never underflows.
- Fflags:
  - fflags_next = (fflags_clr_i ? 0 : fflags_o) | (retire ? rsp_status_o : 0).
  - Retired status wins over a clear in the same cycle.
- Flush:
  - fpu_flush_o = flush_i (combinational).
  - The next state equals the reset state, except fflags_o and proto_err_o are kept.
  - Results arriving in the flush cycle are dropped; no rsp handshake completes during flush.

Optional Feature:
- FPU_ISSUE_TIMEOUT_EN defined:
  - Adds output timeout_o (1 bit, sticky; cleared by reset or flush).
  - A counter runs while the slot at rd_ptr is reserved but not valid and resets on each retire.
  - When the counter reaches TimeoutCycles, timeout_o is set; no other behaviour changes.
- Undefined: no counter and no timeout_o port.

Test Plan:
- Single op:
  - Stimulus: cmd add 0x3C00+0x4000; FPU returns 0x4200 with status 0 three cycles later.
  - Required: fpu_in_valid_o one cycle after accept with fpu_tag_o=0; rsp_valid_o one cycle after the FPU result; rsp_result_o=0x4200; outstanding_o returns to 0.
- Out of order:
  - Stimulus: issue tags 0 and 1; FPU returns tag 1 (0x4400) first, then tag 0 (0x4200).
  - Required: rsp order 0x4200 then 0x4400; rsp_valid_o stays 0 until tag 0 arrives.
- Full:
  - Stimulus: 4 accepted cmds, no FPU results.
  - Required: outstanding_o=4, cmd_ready_o=0.
  - Follow-up: one retire, then cmd_ready_o=1; the next op gets tag 0 (wrap).
- Flush:
  - Stimulus: 3 outstanding ops, flush_i pulse.
  - Required: fpu_flush_o=1 in the same cycle; next cycle outstanding_o=0, rsp_valid_o=0, fflags_o unchanged.
  - Follow-up: a late result for tag 2 sets proto_err_o.
- Fflags:
  - Stimulus: retire status 5'b00001, then 5'b10000 in the same cycle as fflags_clr_i.
  - Required: fflags_o=5'b00001, then 5'b10000.
- Backpressure:
  - Stimulus: fpu_in_ready_i=0 for 5 cycles.
  - Required: fpu_in_valid_o, payload and tag held stable; a second cmd is accepted only after the handshake.
